posit_encode: RTL

POSIT_ENCODE -- requirements
Module: posit_encode

---
 rtl/posit_pkg.sv | 31 +++
 rtl/posit_regime_gen.sv | 32 +++
 rtl/posit_encode.sv | 137 +++++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// posit_pkg: shared constants and types for the posit32 (es = 3) encoder.
//   N, ES          : posit word and exponent field widths
//   K_MAX, K_MIN   : regime values at or beyond which the result saturates
//   NAR            : Not-a-Real encoding
//   MAXPOS, MINPOS : largest and smallest positive magnitudes
//   state_e        : encoder FSM states
package posit_pkg;

    localparam int unsigned N  = 32;
    localparam int unsigned ES = 3;

    localparam logic signed [5:0] K_MAX = 6'sd30;
    localparam logic signed [5:0] K_MIN = -6'sd31;

    // Largest / smallest regime values that still fit a 31-bit body.
    localparam logic signed [5:0] K_FIT_MAX = 6'sd29;
    localparam logic signed [5:0] K_FIT_MIN = -6'sd30;

    localparam logic [31:0] NAR    = 32'h8000_0000;
    localparam logic [31:0] MAXPOS = 32'h7FFF_FFFF;
    localparam logic [31:0] MINPOS = 32'h0000_0001;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StPack = 3'd2,
        StSign = 3'd3,
        StDone = 3'd4
    } state_e;

endpackage

// File: rtl/posit_regime_gen.sv
// posit_regime_gen: combinational regime pattern generator.
//   k_i       : clamped regime value, two's complement, range -30..29
//   pattern_o : regime bits left-aligned at bit 30, zeros below the pattern
//   len_o     : regime length in bits (k+2 for k >= 0, |k|+1 for k < 0)
module posit_regime_gen
    import posit_pkg::*;
(
    input  logic [5:0]  k_i,
    output logic [30:0] pattern_o,
    output logic [4:0]  len_o
);

    logic [4:0] mag;

    // |k| for negative k; range is at most 30 so 5 bits suffice.
    assign mag = ~k_i[4:0] + 5'd1;

    always_comb begin
        pattern_o = '0;
        len_o     = '0;
        if (!k_i[5]) begin
            // k+1 leading ones; the terminating zero is implicit.
            pattern_o = ~({31{1'b1}} >> (k_i[4:0] + 5'd1));
            len_o     = k_i[4:0] + 5'd2;
        end else begin
            // |k| leading zeros then a single terminating one.
            pattern_o = 31'h4000_0000 >> mag;
            len_o     = mag + 5'd1;
        end
    end

endmodule

// File: rtl/posit_encode.sv
// posit_encode: multi-cycle posit32 (es = 3) packer.
//   clk, rst_n   : clock and asynchronous active-low reset
//   start        : request, sampled only in idle
//   mantissa_in  : rounded fraction, MSB-aligned at bit 31
//   k_in         : regime value, two's complement
//   sign_in      : result sign (1 = negative)
//   exp_in       : 3-bit exponent field
//   zero_in      : result is exact zero
//   nar_in       : result is NaR
//   posit_out    : encoded word, held until the next completion
//   done         : one-cycle pulse when posit_out is fresh
//   busy         : high whenever an operation is in flight
module posit_encode
    import posit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] mantissa_in,
    input  logic [5:0]  k_in,
    input  logic        sign_in,
    input  logic [2:0]  exp_in,
    input  logic        zero_in,
    input  logic        nar_in,
    output logic [31:0] posit_out,
    output logic        done,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [31:0] mant_q;
    logic [5:0]  k_q, k_d;
    logic [2:0]  exp_q;
    logic        sign_q, zero_q, nar_q;
    logic        sat_q, sat_d;
    logic        minpos_q, minpos_d;
    logic [30:0] body_q, body_d;
    logic [31:0] posit_q, posit_d;

    logic [30:0] regime_pattern;
    logic [4:0]  regime_len;

    posit_regime_gen u_regime (
        .k_i       (k_q),
        .pattern_o (regime_pattern),
        .len_o     (regime_len)
    );

    // Load-stage clamp; the flags take over the result, and the clamped k
    // just keeps the regime generator inside its legal range.
    always_comb begin
        sat_d    = $signed(k_in) >= K_MAX;
        minpos_d = $signed(k_in) <= K_MIN;
        k_d      = k_in;
        if (sat_d) begin
            k_d = K_FIT_MAX;
        end else if (minpos_d) begin
            k_d = K_FIT_MIN;
        end
    end

    // Pack stage: exponent and fraction follow the regime; anything shifted
    // past bit 0 is dropped because rounding was done upstream.
    always_comb begin
        if (sat_q) begin
            body_d = MAXPOS[30:0];
        end else if (minpos_q) begin
            body_d = MINPOS[30:0];
        end else begin
            body_d = regime_pattern | 31'(({exp_q, mant_q} >> regime_len) >> 4);
        end
    end

    // Sign stage: NaR beats zero, both beat the magnitude path.
    always_comb begin
        if (nar_q) begin
            posit_d = NAR;
        end else if (zero_q) begin
            posit_d = '0;
        end else if (sign_q) begin
            posit_d = ~{1'b0, body_q} + 32'd1;
        end else begin
            posit_d = {1'b0, body_q};
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StPack;
            StPack:  state_d = StSign;
            StSign:  state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            mant_q   <= '0;
            k_q      <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            zero_q   <= 1'b0;
            nar_q    <= 1'b0;
            sat_q    <= 1'b0;
            minpos_q <= 1'b0;
            body_q   <= '0;
            posit_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StLoad) begin
                mant_q   <= mantissa_in;
                k_q      <= k_d;
                exp_q    <= exp_in;
                sign_q   <= sign_in;
                zero_q   <= zero_in;
                nar_q    <= nar_in;
                sat_q    <= sat_d;
                minpos_q <= minpos_d;
            end
            if (state_q == StPack) begin
                body_q <= body_d;
            end
            if (state_q == StSign) begin
                posit_q <= posit_d;
            end
        end
    end

    assign posit_out = posit_q;
    assign done      = (state_q == StDone);
    assign busy      = (state_q != StIdle);

endmodule
